// File: rtl/ad9851_pkg.sv
// AD9851 serial-load shared types and constants.
// State encoding, word geometry and control-byte fields.
package ad9851_pkg;

  typedef enum logic [2:0] {
    INIT_RST,
    INIT_WCLK,
    INIT_FQUD,
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    COMMIT
  } state_t;

  localparam int WORD_BITS   = 40;
  localparam int FTW_BITS    = 32;
  localparam int CTRL_BITS   = 8;

  localparam int REFMULT_BIT = 0;
  localparam int PWRDN_BIT   = 2;
  localparam int PHASE_LSB   = 3;
  localparam int PHASE_W     = 5;

  function automatic int cnt_w(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ad9851_load_sequencer_if.sv
// Requester-side bus of the AD9851 load sequencer.
// The requesters are master, the sequencer is slave.
interface ad9851_load_sequencer_if;
  import ad9851_pkg::*;

  logic                 cfg_req;
  logic [FTW_BITS-1:0]  cfg_ftw;
  logic [CTRL_BITS-1:0] cfg_ctrl;
  logic                 cfg_ack;
  logic                 sym_req;
  logic [FTW_BITS-1:0]  sym_ftw;
  logic                 sym_ack;
  logic                 ready;
  logic                 busy;
  logic                 load_done;

  modport master (
    output cfg_req, cfg_ftw, cfg_ctrl,
    output sym_req, sym_ftw,
    input  cfg_ack, sym_ack,
    input  ready, busy, load_done
  );

  modport slave (
    input  cfg_req, cfg_ftw, cfg_ctrl,
    input  sym_req, sym_ftw,
    output cfg_ack, sym_ack,
    output ready, busy, load_done
  );

endinterface

// File: rtl/ad9851_serial_shifter.sv
// 40-bit LSB-first serial shifter with W_CLK timing.
// done strobes in the last W_CLK-high cycle of bit 39.
module ad9851_serial_shifter
  import ad9851_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] word,
  output logic                 tick,
  output logic                 done,
  output logic                 wclk,
  output logic                 data
);

  localparam int CW = cnt_w(CLK_DIV);

  logic [WORD_BITS-1:0] shift_reg;
  logic [5:0]           bit_idx;
  logic [CW-1:0]        cnt;
  logic                 hi;
  logic                 active;

  assign tick = active && (cnt == CW'(CLK_DIV - 1));
  assign done = tick && hi && (bit_idx == 6'(WORD_BITS - 1));

  // Half-period timing, bit stepping and pin registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_idx   <= '0;
      cnt       <= '0;
      hi        <= 1'b0;
      active    <= 1'b0;
      wclk      <= 1'b0;
      data      <= 1'b0;
    end else if (load) begin
      shift_reg <= word;
      bit_idx   <= '0;
      cnt       <= '0;
      hi        <= 1'b0;
      active    <= 1'b1;
      wclk      <= 1'b0;
      data      <= word[0];
    end else if (active) begin
      if (!tick) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        if (!hi) begin
          hi   <= 1'b1;
          wclk <= 1'b1;
        end else if (done) begin
          hi     <= 1'b0;
          wclk   <= 1'b0;
          active <= 1'b0;
        end else begin
          hi      <= 1'b0;
          wclk    <= 1'b0;
          bit_idx <= bit_idx + 6'd1;
          data    <= shift_reg[bit_idx + 6'd1];
        end
      end
    end
  end

endmodule

// File: rtl/ad9851_load_sequencer.sv
// AD9851 serial-mode init, sym/cfg arbitration and commit.
// Words go out through ad9851_serial_shifter.
module ad9851_load_sequencer
  import ad9851_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int RST_CYCLES  = 8,
  parameter int FQUD_CYCLES = 2,
  parameter int MAX_SYM_RUN = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  ad9851_load_sequencer_if.slave   bus,
  output logic                     dds_reset,
  output logic                     dds_wclk,
  output logic                     dds_fqud,
  output logic                     dds_data
);

  localparam int CW =
    cnt_w(max3(CLK_DIV, RST_CYCLES, FQUD_CYCLES));
  localparam int RW = cnt_w(MAX_SYM_RUN + 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CTRL_BITS-1:0] ctrl_reg;
  logic [RW-1:0]        sym_run;
  logic                 init_wclk;
  logic                 sym_win;
  logic                 cfg_win;
  logic                 load;
  logic [WORD_BITS-1:0] word;
  logic                 sh_tick;
  logic                 sh_done;
  logic                 sh_wclk;

  // IDLE arbitration: sym by default, cfg once sym has had its run.
  always_comb begin
    sym_win = bus.sym_req &&
              !(bus.cfg_req && (sym_run == RW'(MAX_SYM_RUN)));
    cfg_win = bus.cfg_req && !sym_win;
    load    = (state == IDLE) && (sym_win || cfg_win);
    word    = sym_win ? {ctrl_reg, bus.sym_ftw}
                      : {bus.cfg_ctrl, bus.cfg_ftw};
  end

  ad9851_serial_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk  (ACLK),
    .rst  (ARESET),
    .load (load),
    .word (word),
    .tick (sh_tick),
    .done (sh_done),
    .wclk (sh_wclk),
    .data (dds_data)
  );

  // Init only drives W_CLK while the shifter is idle.
  assign dds_wclk = init_wclk | sh_wclk;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state         <= INIT_RST;
      cnt           <= '0;
      ctrl_reg      <= '0;
      sym_run       <= '0;
      init_wclk     <= 1'b0;
      dds_reset     <= 1'b1;
      dds_fqud      <= 1'b0;
      bus.cfg_ack   <= 1'b0;
      bus.sym_ack   <= 1'b0;
      bus.ready     <= 1'b0;
      bus.busy      <= 1'b1;
      bus.load_done <= 1'b0;
    end else begin
      bus.cfg_ack   <= 1'b0;
      bus.sym_ack   <= 1'b0;
      bus.load_done <= 1'b0;
      if (!bus.cfg_req) sym_run <= '0;
      unique case (state)
        INIT_RST: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            cnt       <= '0;
            dds_reset <= 1'b0;
            init_wclk <= 1'b1;
            state     <= INIT_WCLK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT_WCLK: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt       <= '0;
            init_wclk <= 1'b0;
            dds_fqud  <= 1'b1;
            state     <= INIT_FQUD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT_FQUD: begin
          if (cnt == CW'(FQUD_CYCLES - 1)) begin
            cnt       <= '0;
            dds_fqud  <= 1'b0;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (load) begin
            bus.busy <= 1'b1;
            state    <= SHIFT_LO;
            if (sym_win) begin
              bus.sym_ack <= 1'b1;
              if (bus.cfg_req &&
                  sym_run != RW'(MAX_SYM_RUN))
                sym_run <= sym_run + 1'b1;
            end else begin
              bus.cfg_ack <= 1'b1;
              ctrl_reg    <= bus.cfg_ctrl;
              sym_run     <= '0;
            end
          end
        end
        SHIFT_LO: begin
          if (sh_tick) state <= SHIFT_HI;
        end
        SHIFT_HI: begin
          if (sh_done) begin
            cnt      <= '0;
            dds_fqud <= 1'b1;
            state    <= COMMIT;
          end else if (sh_tick) begin
            state <= SHIFT_LO;
          end
        end
        COMMIT: begin
          if (cnt == CW'(FQUD_CYCLES - 1)) begin
            cnt           <= '0;
            dds_fqud      <= 1'b0;
            bus.load_done <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= INIT_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9851_load_sequencer.sv
// Directed bench for ad9851_load_sequencer.
// A negedge monitor rebuilds each word from the pins.
module tb_ad9851_load_sequencer;
  import ad9851_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dds_reset, dds_wclk, dds_fqud, dds_data;

  ad9851_load_sequencer_if bus();

  ad9851_load_sequencer #(
    .CLK_DIV     (2),
    .RST_CYCLES  (8),
    .FQUD_CYCLES (2),
    .MAX_SYM_RUN (4)
  ) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .bus       (bus.slave),
    .dds_reset (dds_reset),
    .dds_wclk  (dds_wclk),
    .dds_fqud  (dds_fqud),
    .dds_data  (dds_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pin monitor
  logic [39:0] cap = '0;
  int          nbits = 0;
  logic        wq = 1'b0;
  logic        fq = 1'b0;
  logic [39:0] words[$];
  int          nbits_q[$];
  int          fq_at[$];
  int          ack_at[$];
  bit          ack_sym[$];
  int          ndone = 0;

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
      cap   = '0;
    end else if (bus.ready) begin
      if (dds_wclk && !wq) begin
        cap   = {dds_data, cap[39:1]};
        nbits = nbits + 1;
      end
      if (dds_fqud && !fq) begin
        words.push_back(cap);
        nbits_q.push_back(nbits);
        fq_at.push_back(cyc);
        nbits = 0;
      end
      if (bus.load_done) ndone = ndone + 1;
      if (bus.cfg_ack) begin
        ack_at.push_back(cyc);
        ack_sym.push_back(1'b0);
      end
      if (bus.sym_ack) begin
        ack_at.push_back(cyc);
        ack_sym.push_back(1'b1);
      end
    end
    wq = dds_wclk;
    fq = dds_fqud;
  end

  bit sym_hold = 1'b0;

  // one cycle; requesters drop req on their ack
  task automatic tick();
    @(negedge clk);
    if (bus.cfg_ack) bus.cfg_req = 1'b0;
    if (bus.sym_ack && !sym_hold) bus.sym_req = 1'b0;
  endtask

  task automatic wait_acks(int n);
    int k = 0;
    while (ack_at.size() < n && k < 3000) begin
      tick();
      k++;
    end
    check("ack_wait", 64'(ack_at.size() >= n), 64'd1);
  endtask

  task automatic wait_words(int n);
    int k = 0;
    while (words.size() < n && k < 3000) begin
      tick();
      k++;
    end
    check("word_wait", 64'(words.size() >= n), 64'd1);
    repeat (4) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, nw, nf, k, t0, nd, nwd, early;
    bit exp_src[6];

    bus.cfg_req  = 1'b0;
    bus.cfg_ftw  = '0;
    bus.cfg_ctrl = '0;
    bus.sym_req  = 1'b0;
    bus.sym_ftw  = '0;

    // 1: reset values and init sequence
    repeat (3) @(negedge clk);
    check("rst_vals",
      {dds_reset, dds_wclk, dds_fqud, dds_data,
       bus.ready, bus.busy, bus.cfg_ack, bus.sym_ack,
       bus.load_done}, 64'b100001000);
    rst = 1'b0;
    nr = 0; nw = 0; nf = 0; k = 0;
    while (!bus.ready && k < 100) begin
      nr += int'(dds_reset);
      nw += int'(dds_wclk);
      nf += int'(dds_fqud);
      tick();
      k++;
    end
    check("init_rst_cyc", 64'(nr), 64'd8);
    check("init_wclk_cyc", 64'(nw), 64'd2);
    check("init_fqud_cyc", 64'(nf), 64'd2);
    check("init_ready", 64'(bus.ready), 64'd1);
    check("init_busy", 64'(bus.busy), 64'd0);
    check("init_quiet", {dds_reset, dds_wclk, dds_fqud}, 64'd0);

    // 2: single cfg load
    bus.cfg_ftw  = 32'h12345678;
    bus.cfg_ctrl = 8'h01;
    bus.cfg_req  = 1'b1;
    t0 = cyc;
    wait_words(1);
    check("t2_ack_lat", 64'(ack_at[0] - t0), 64'd1);
    check("t2_src", 64'(ack_sym[0]), 64'd0);
    check("t2_word", 64'(words[0]), 64'h0112345678);
    check("t2_bits", 64'(nbits_q[0]), 64'd40);
    check("t2_fqud_lat", 64'(fq_at[0] - (ack_at[0] - 1)), 64'd161);
    check("t2_done", 64'(ndone), 64'd1);

    // 3: simultaneous sym and cfg
    bus.sym_ftw  = 32'hAAAA5555;
    bus.cfg_ftw  = 32'h0BADF00D;
    bus.cfg_ctrl = 8'h09;
    bus.sym_req  = 1'b1;
    bus.cfg_req  = 1'b1;
    wait_words(3);
    check("t3_src1", 64'(ack_sym[1]), 64'd1);
    check("t3_src2", 64'(ack_sym[2]), 64'd0);
    check("t3_word1", 64'(words[1]), 64'h01AAAA5555);
    check("t3_word2", 64'(words[2]), 64'h090BADF00D);
    check("t3_period", 64'(ack_at[2] - ack_at[1]), 64'd163);
    check("t3_done", 64'(ndone), 64'd3);

    // 4: sym run limit with cfg pending
    bus.cfg_ftw  = 32'h00000055;
    bus.cfg_ctrl = 8'h01;
    bus.sym_ftw  = 32'h11110000;
    sym_hold     = 1'b1;
    bus.sym_req  = 1'b1;
    bus.cfg_req  = 1'b1;
    wait_acks(9);
    sym_hold    = 1'b0;
    bus.sym_req = 1'b0;
    wait_words(9);
    exp_src = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++)
      check($sformatf("t4_src%0d", i),
            64'(ack_sym[3 + i]), 64'(exp_src[i]));
    check("t4_sym_word", 64'(words[6]), 64'h0911110000);
    check("t4_cfg_word", 64'(words[7]), 64'h0100000055);
    check("t4_resume", 64'(words[8]), 64'h0111110000);

    // 6: power-down ctrl carried into next sym word
    bus.cfg_ftw  = 32'h01020304;
    bus.cfg_ctrl = 8'h04;
    bus.cfg_req  = 1'b1;
    wait_words(10);
    bus.sym_ftw = 32'hDEADBEEF;
    bus.sym_req = 1'b1;
    wait_words(11);
    check("t6_cfg_word", 64'(words[9]), 64'h0401020304);
    check("t6_sym_word", 64'(words[10]), 64'h04DEADBEEF);

    // 5: reset mid-word, pending sym served afresh
    bus.cfg_ftw  = 32'hCAFEF00D;
    bus.cfg_ctrl = 8'h20;
    bus.cfg_req  = 1'b1;
    bus.sym_ftw  = 32'h13579BDF;
    wait_acks(12);
    bus.sym_req = 1'b1;
    k = 0;
    while (nbits < 20 && k < 500) begin
      tick();
      k++;
    end
    check("t5_reach_bit20", 64'(nbits), 64'd20);
    nd  = ndone;
    nwd = words.size();
    rst = 1'b1;
    #1;
    check("t5_abort_pins",
      {dds_wclk, dds_reset, dds_fqud, bus.ready, bus.busy},
      64'b01001);
    repeat (3) tick();
    rst = 1'b0;
    early = 0;
    k = 0;
    while (!bus.ready && k < 100) begin
      early += int'(bus.sym_ack);
      tick();
      k++;
    end
    check("t5_no_early_ack", 64'(early), 64'd0);
    check("t5_reinit", 64'(bus.ready), 64'd1);
    wait_words(nwd + 1);
    check("t5_words", 64'(words.size()), 64'(nwd + 1));
    check("t5_new_word", 64'(words[nwd]), 64'h0013579BDF);
    check("t5_done", 64'(ndone), 64'(nd + 1));
    check("t5_ack_src", 64'(ack_sym[ack_at.size() - 1]), 64'd1);
    check("t5_acks", 64'(ack_at.size()), 64'd13);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
